// File: rtl/ov7670_pkg.sv
// Shared state codes, pin-level output decode and default 25 MHz timing for the OV7670 bring-up path.
// Purely declarative: no logic, no latency, no flow control.
package ov7670_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_PWDN      = 3'd1,
    ST_RESET     = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_CFG_START = 3'd4,
    ST_CFG_WAIT  = 3'd5,
    ST_RUN       = 3'd6,
    ST_FAULT     = 3'd7
  } state_t;

  typedef struct packed {
    logic pwdn;
    logic resetn;
    logic start;
    logic cap_en;
    logic ready;
    logic fault;
  } pins_t;

  // Defaults at 25 MHz: 1 ms PWDN, 1 ms RESET#, 1 s settle, 2 s watchdog.
  localparam int DEF_LOCK_FILTER        = 1024;
  localparam int DEF_PWDN_CYCLES        = 25000;
  localparam int DEF_RESET_CYCLES       = 25000;
  localparam int DEF_SETTLE_CYCLES      = 25000000;
  localparam int DEF_CFG_TIMEOUT_CYCLES = 50000000;
  localparam int DEF_MAX_RETRIES        = 3;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic pins_t decode_pins(input state_t s);
    pins_t p;
    p = '{pwdn: 1'b1, resetn: 1'b0, start: 1'b0, cap_en: 1'b0, ready: 1'b0, fault: 1'b0};
    unique case (s)
      ST_WAIT_LOCK, ST_PWDN: p.pwdn = 1'b1;
      ST_RESET:              p.pwdn = 1'b0;
      ST_SETTLE, ST_CFG_WAIT: begin
        p.pwdn   = 1'b0;
        p.resetn = 1'b1;
      end
      ST_CFG_START: begin
        p.pwdn   = 1'b0;
        p.resetn = 1'b1;
        p.start  = 1'b1;
      end
      ST_RUN: begin
        p.pwdn   = 1'b0;
        p.resetn = 1'b1;
        p.cap_en = 1'b1;
        p.ready  = 1'b1;
      end
      ST_FAULT: p.fault = 1'b1;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/seq_delay_timer.sv
// Loadable down-counter; done is high while the count sits at zero, so loading N-1 gives an N-cycle interval.
// Load takes effect on the next edge; no backpressure, counts freely and holds at zero.
module seq_delay_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/ov7670_bringup_seq.sv
// OV7670 power-up/config sequencer: PLL lock filter, PWDN/RESET# timing, supervised SCCB load, capture enable.
// Moore outputs (one cycle after inputs); CFG_WAIT watchdog only when BRINGUP_TIMEOUT_EN is defined.
module ov7670_bringup_seq
  import ov7670_pkg::*;
#(
  parameter int LOCK_FILTER        = DEF_LOCK_FILTER,
  parameter int PWDN_CYCLES        = DEF_PWDN_CYCLES,
  parameter int RESET_CYCLES       = DEF_RESET_CYCLES,
  parameter int SETTLE_CYCLES      = DEF_SETTLE_CYCLES,
  parameter int CFG_TIMEOUT_CYCLES = DEF_CFG_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES        = DEF_MAX_RETRIES
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Pll_Locked,
  input  logic       i_Cfg_Done,
  input  logic       i_Cfg_Err,
  output logic       o_Cam_Pwdn,
  output logic       o_Cam_Resetn,
  output logic       o_Cfg_Start,
  output logic       o_Capture_En,
  output logic       o_Ready,
  output logic       o_Fault,
  output logic [2:0] o_State
);

`ifdef BRINGUP_TIMEOUT_EN
  localparam int TMR_MAX = max2(max2(PWDN_CYCLES, RESET_CYCLES),
                                max2(SETTLE_CYCLES, CFG_TIMEOUT_CYCLES));
`else
  localparam int TMR_MAX = max2(max2(PWDN_CYCLES, RESET_CYCLES), SETTLE_CYCLES);
`endif
  localparam int TW = $clog2(TMR_MAX + 1);
  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  localparam logic [TW-1:0] PWDN_LOAD   = TW'(PWDN_CYCLES - 1);
  localparam logic [TW-1:0] RESET_LOAD  = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
`ifdef BRINGUP_TIMEOUT_EN
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(CFG_TIMEOUT_CYCLES - 1);
`endif
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);

  state_t        state;
  state_t        state_nxt;
  logic [FW-1:0] filt_cnt;
  logic [FW-1:0] filt_nxt;
  logic [RW-1:0] retry_cnt;
  logic [RW-1:0] retry_nxt;
  logic          tmr_load;
  logic [TW-1:0] tmr_value;
  logic          tmr_done;
  logic          cfg_expired;
  pins_t         pins;

  seq_delay_timer #(.W(TW)) u_timer (
    .clk   (i_Clk),
    .rst   (i_Rst),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done)
  );

`ifdef BRINGUP_TIMEOUT_EN
  assign cfg_expired = tmr_done;
`else
  assign cfg_expired = 1'b0;
`endif

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state     <= ST_WAIT_LOCK;
      filt_cnt  <= '0;
      retry_cnt <= '0;
    end else begin
      state     <= state_nxt;
      filt_cnt  <= filt_nxt;
      retry_cnt <= retry_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    tmr_load  = 1'b0;
    tmr_value = '0;

    unique case (state)
      ST_WAIT_LOCK: begin
        if (i_Pll_Locked && filt_cnt == FILT_LAST) begin
          state_nxt = ST_PWDN;
          tmr_load  = 1'b1;
          tmr_value = PWDN_LOAD;
        end
      end
      ST_PWDN: begin
        if (tmr_done) begin
          state_nxt = ST_RESET;
          tmr_load  = 1'b1;
          tmr_value = RESET_LOAD;
        end
      end
      ST_RESET: begin
        if (tmr_done) begin
          state_nxt = ST_SETTLE;
          tmr_load  = 1'b1;
          tmr_value = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (tmr_done) state_nxt = ST_CFG_START;
      end
      ST_CFG_START: begin
        state_nxt = ST_CFG_WAIT;
`ifdef BRINGUP_TIMEOUT_EN
        tmr_load  = 1'b1;
        tmr_value = TIMEOUT_LOAD;
`endif
      end
      ST_CFG_WAIT: begin
        // Err is checked first so a simultaneous Done/Err counts as a failure.
        if (i_Cfg_Err || cfg_expired) begin
          retry_nxt = retry_cnt + RW'(1);
          if (int'(retry_nxt) < MAX_RETRIES) begin
            state_nxt = ST_RESET;
            tmr_load  = 1'b1;
            tmr_value = RESET_LOAD;
          end else begin
            state_nxt = ST_FAULT;
          end
        end else if (i_Cfg_Done) begin
          state_nxt = ST_RUN;
          retry_nxt = '0;
        end
      end
      ST_RUN:   state_nxt = ST_RUN;
      ST_FAULT: state_nxt = ST_FAULT;
    endcase

    // Lock loss overrides everything except the terminal fault; retry history survives.
    if (!i_Pll_Locked && state != ST_WAIT_LOCK && state != ST_FAULT) begin
      state_nxt = ST_WAIT_LOCK;
      retry_nxt = retry_cnt;
      tmr_load  = 1'b0;
      tmr_value = '0;
    end
  end

  always_comb begin
    filt_nxt = '0;
    if (state == ST_WAIT_LOCK && i_Pll_Locked && state_nxt == ST_WAIT_LOCK) begin
      filt_nxt = filt_cnt + FW'(1);
    end
  end

  assign pins         = decode_pins(state);
  assign o_Cam_Pwdn   = pins.pwdn;
  assign o_Cam_Resetn = pins.resetn;
  assign o_Cfg_Start  = pins.start;
  assign o_Capture_En = pins.cap_en;
  assign o_Ready      = pins.ready;
  assign o_Fault      = pins.fault;
  assign o_State      = state;

endmodule

// File: tb/tb_ov7670_bringup_seq.sv
// Directed bench for ov7670_bringup_seq with short delays; expectations queued per cycle and checked at negedge.
module tb_ov7670_bringup_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic locked = 1'b0;
  logic cfg_done = 1'b0;
  logic cfg_err = 1'b0;
  logic cam_pwdn, cam_resetn, cfg_start, capture_en, ready, fault;
  logic [2:0] state;

  ov7670_bringup_seq #(
    .LOCK_FILTER(4), .PWDN_CYCLES(8), .RESET_CYCLES(8), .SETTLE_CYCLES(16),
    .CFG_TIMEOUT_CYCLES(100), .MAX_RETRIES(2)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Pll_Locked(locked),
    .i_Cfg_Done(cfg_done), .i_Cfg_Err(cfg_err),
    .o_Cam_Pwdn(cam_pwdn), .o_Cam_Resetn(cam_resetn), .o_Cfg_Start(cfg_start),
    .o_Capture_En(capture_en), .o_Ready(ready), .o_Fault(fault), .o_State(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      tag;
    logic [8:0] exp;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int edge_cnt = 0;
  int t0 = 0;

  wire [8:0] obs = {state, cam_pwdn, cam_resetn, cfg_start, capture_en, ready, fault};

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Pin table: Pwdn/Resetn/Start/CapEn/Ready/Fault for each state code.
  function automatic logic [8:0] exp_vec(input logic [2:0] st);
    logic [5:0] p;
    case (st)
      3'd0, 3'd1: p = 6'b100000;
      3'd2:       p = 6'b000000;
      3'd3, 3'd5: p = 6'b010000;
      3'd4:       p = 6'b011000;
      3'd6:       p = 6'b010110;
      default:    p = 6'b100001;
    endcase
    return {st, p};
  endfunction

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    int cur;
    cur = edge_cnt - t0;
    while (sb.size() > 0 && sb[0].cyc <= cur) begin
      e = sb.pop_front();
      if (e.cyc < cur) begin
        vectors++;
        miscompares++;
        $error("FAIL %s: not sampled at cycle %0d (now %0d), expected %h", e.tag, e.cyc, cur, e.exp);
      end else begin
        check(e.tag, obs, e.exp);
      end
    end
  end

  task automatic expect_st(input int c, input logic [2:0] st, input string tag);
    exp_t e;
    e.cyc = c;
    e.tag = tag;
    e.exp = exp_vec(st);
    sb.push_back(e);
  endtask

  task automatic wait_cycle(input int c);
    while (edge_cnt - t0 < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int c, input logic d, input logic e);
    wait_cycle(c);
    cfg_done = d;
    cfg_err  = e;
    wait_cycle(c + 1);
    cfg_done = 1'b0;
    cfg_err  = 1'b0;
  endtask

  task automatic set_lock(input int c, input logic v);
    wait_cycle(c);
    locked = v;
  endtask

  task automatic drain(input int c);
    wait_cycle(c + 1);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      miscompares++;
      $error("FAIL %s: never sampled, expected %h", e.tag, e.exp);
    end
  endtask

  // Cycle 0 is the period following the last reset-high edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    locked = 1'b1;
    cfg_done = 1'b0;
    cfg_err = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check(tag, obs, exp_vec(3'd0));
    rst = 1'b0;
    t0 = edge_cnt;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Nominal bring-up, with a stray Err in SETTLE that must be ignored.
    do_reset("reset_t1");
    expect_st(0, 3'd0, "t1_c0_wait");
    expect_st(3, 3'd0, "t1_c3_wait");
    expect_st(4, 3'd1, "t1_c4_pwdn");
    expect_st(11, 3'd1, "t1_c11_pwdn");
    expect_st(12, 3'd2, "t1_c12_reset");
    expect_st(19, 3'd2, "t1_c19_reset");
    expect_st(20, 3'd3, "t1_c20_settle");
    expect_st(26, 3'd3, "t1_c26_stray_err");
    expect_st(35, 3'd3, "t1_c35_settle");
    expect_st(36, 3'd4, "t1_c36_start");
    expect_st(37, 3'd5, "t1_c37_wait");
    expect_st(41, 3'd5, "t1_c41_wait");
    expect_st(42, 3'd6, "t1_c42_run");
    expect_st(43, 3'd6, "t1_c43_run");
    pulse(25, 1'b0, 1'b1);
    pulse(41, 1'b1, 1'b0);
    drain(43);

    // Lock glitch restarts the filter.
    do_reset("reset_t2");
    expect_st(2, 3'd0, "t2_c2_wait");
    expect_st(6, 3'd0, "t2_c6_wait");
    expect_st(7, 3'd1, "t2_c7_pwdn");
    set_lock(2, 1'b0);
    set_lock(3, 1'b1);
    drain(7);

    // One Err then Done.
    do_reset("reset_t3");
    expect_st(40, 3'd5, "t3_c40_wait");
    expect_st(41, 3'd2, "t3_c41_reset");
    expect_st(48, 3'd2, "t3_c48_reset");
    expect_st(49, 3'd3, "t3_c49_settle");
    expect_st(64, 3'd3, "t3_c64_settle");
    expect_st(65, 3'd4, "t3_c65_start2");
    expect_st(66, 3'd5, "t3_c66_wait2");
    expect_st(68, 3'd5, "t3_c68_wait2");
    expect_st(69, 3'd6, "t3_c69_run");
    pulse(40, 1'b0, 1'b1);
    pulse(68, 1'b1, 1'b0);
    drain(69);

    // Exhaustion; second failure is Done+Err together. FAULT ignores lock and Done.
    do_reset("reset_t4");
    expect_st(41, 3'd2, "t4_c41_reset");
    expect_st(65, 3'd4, "t4_c65_start2");
    expect_st(67, 3'd5, "t4_c67_wait2");
    expect_st(68, 3'd7, "t4_c68_fault");
    expect_st(71, 3'd7, "t4_c71_fault_unlock");
    expect_st(73, 3'd7, "t4_c73_fault_relock");
    expect_st(75, 3'd7, "t4_c75_fault_done");
    expect_st(80, 3'd7, "t4_c80_fault");
    pulse(40, 1'b0, 1'b1);
    pulse(67, 1'b1, 1'b1);
    set_lock(70, 1'b0);
    set_lock(72, 1'b1);
    pulse(74, 1'b1, 1'b0);
    drain(80);

    // No response from the config engine.
    do_reset("reset_t5");
`ifdef BRINGUP_TIMEOUT_EN
    expect_st(37, 3'd5, "t5_c37_wait");
    expect_st(136, 3'd5, "t5_c136_wait");
    expect_st(137, 3'd2, "t5_c137_retry");
    expect_st(161, 3'd4, "t5_c161_start2");
    expect_st(162, 3'd5, "t5_c162_wait2");
    expect_st(261, 3'd5, "t5_c261_wait2");
    expect_st(262, 3'd7, "t5_c262_fault");
    drain(262);
`else
    expect_st(37, 3'd5, "t5_c37_wait");
    expect_st(1037, 3'd5, "t5_c1037_still_wait");
    drain(1037);
`endif

    // Lock loss in RUN.
    do_reset("reset_t6a");
    expect_st(42, 3'd6, "t6a_c42_run");
    expect_st(45, 3'd6, "t6a_c45_run");
    expect_st(46, 3'd0, "t6a_c46_lost");
    expect_st(48, 3'd0, "t6a_c48_wait");
    expect_st(52, 3'd1, "t6a_c52_pwdn");
    pulse(41, 1'b1, 1'b0);
    set_lock(45, 1'b0);
    set_lock(48, 1'b1);
    drain(52);

    // Lock loss after one failure keeps the retry count.
    do_reset("reset_t6b");
    expect_st(41, 3'd2, "t6b_c41_reset");
    expect_st(49, 3'd3, "t6b_c49_settle");
    expect_st(51, 3'd0, "t6b_c51_lost");
    expect_st(55, 3'd1, "t6b_c55_pwdn");
    expect_st(87, 3'd4, "t6b_c87_start");
    expect_st(88, 3'd5, "t6b_c88_wait");
    expect_st(91, 3'd7, "t6b_c91_fault");
    pulse(40, 1'b0, 1'b1);
    set_lock(50, 1'b0);
    set_lock(51, 1'b1);
    pulse(90, 1'b0, 1'b1);
    drain(91);

    // Async reset mid-SETTLE, then a clean restart.
    do_reset("reset_t6c");
    expect_st(25, 3'd3, "t6c_c25_settle");
    wait_cycle(26);
    #2;
    rst = 1'b1;
    #1;
    check("t6c_async_rst", obs, exp_vec(3'd0));
    do_reset("reset_t6c_again");
    expect_st(3, 3'd0, "t6c_c3_wait");
    expect_st(4, 3'd1, "t6c_c4_pwdn");
    drain(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
